// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    localparam int          WORD_W            = 32;
    localparam logic [1:0]  ALIGN_MASK        = 2'b11;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - byte-enable synchronous-write RAM with registered read port
//
// Ports:
//   clk    rising-edge clock
//   we     write strobe; bytes selected by be are written at idx
//   re     read strobe; rdata captures mem[idx] and holds until the next read
//   be     byte enables, be[0] covers bits 7:0
//   idx    word index
//   wdata  write data
//   rdata  registered read data
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic                    re,
    input  logic [3:0]              be,
    input  logic [ADDR_W_WORDS-1:0] idx,
    input  logic [WORD_W-1:0]       wdata,
    output logic [WORD_W-1:0]       rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder for the memory stage with fixed wait states
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we/addr/wdata/be     request payload, sampled only at acceptance
//   resp_valid/resp_ready    response handshake
//   resp_rdata, resp_err     response payload, stable while resp_valid is high
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W_WORDS = 8,
    parameter int          WAIT_CYCLES  = 2,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam logic [31:0] DEPTH    = 32'(1) << ADDR_W_WORDS;
    localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);

    dmem_state_t state, state_next;

    logic [3:0]        cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              err_q;
    logic              rdata_ok_q;

    logic [31:0]       offset;
    logic              addr_err;
    logic              ram_we;
    logic              ram_re;
    logic [WORD_W-1:0] ram_rdata;

    // Offset is taken only after the below-base test rejects wrapped values.
    assign offset   = addr_q - BASE_ADDR;
    assign addr_err = ((addr_q[1:0] & ALIGN_MASK) != 2'b00)
                   || (addr_q < BASE_ADDR)
                   || ((offset >> 2) >= DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (WAIT_LD != 4'd0) ? WAIT : COMMIT;
            WAIT:    if (cnt == 4'd1) state_next = COMMIT;
            COMMIT:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A reset landing on the COMMIT edge drops the request, so the write is gated too.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        ram_we     = (state == COMMIT) && we_q && !addr_err && !rst;
        ram_re     = (state == COMMIT) && !we_q && !addr_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            err_q      <= 1'b0;
            rdata_ok_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt     <= WAIT_LD;
                    end
                end
                WAIT:   cnt <= cnt - 4'd1;
                COMMIT: begin
                    err_q      <= addr_err;
                    rdata_ok_q <= !we_q && !addr_err;
                end
                default: ;
            endcase
        end
    end

    dmem_ram #(
        .ADDR_W_WORDS(ADDR_W_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .be    (be_q),
        .idx   (offset[ADDR_W_WORDS+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // The RAM read register doubles as the response data register; stores and
    // errors mask it to zero.
    assign resp_rdata = rdata_ok_q ? ram_rdata : 32'h0;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_ready;
    int          sel;

    logic        rr  [3];
    logic        rv  [3];
    logic        rer [3];
    logic [31:0] rd  [3];

    int          wc   [3] = '{2, 0, 2};
    logic [31:0] base [3] = '{32'h0, 32'h0, 32'h100};
    logic [31:0] mdl  [3][256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W_WORDS(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(rr[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_err(rer[0]));

    dmem_responder #(.ADDR_W_WORDS(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(rr[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_err(rer[1]));

    dmem_responder #(.ADDR_W_WORDS(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h100)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2), .req_ready(rr[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_rdata(rd[2]), .resp_err(rer[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request on instance inst, measures latency, optionally
    // backpressures for hold cycles, then completes the response handshake.
    task automatic xact(input int inst, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output logic [31:0] rdo, output logic erro);
        int guard;
        int lat;
        sel       = inst;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        guard = 0;
        while (!rr[inst] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_ready_idle", 32'(rr[inst]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 0;
        while (!rv[inst] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(wc[inst] + 1));
        rdo  = rd[inst];
        erro = rer[inst];
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check_eq("hold_valid", 32'(rv[inst]), 32'd1);
            check_eq("hold_rdata", rd[inst], rdo);
            check_eq("hold_err", 32'(rer[inst]), 32'(erro));
            check_eq("hold_req_ready", 32'(rr[inst]), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("post_resp_valid", 32'(rv[inst]), 32'd0);
        check_eq("post_req_ready", 32'(rr[inst]), 32'd1);
    endtask

    // Reference: error and data computed from address arithmetic on a word array.
    task automatic run(input int inst, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rdo, output logic erro);
        logic [31:0] off;
        logic        e;
        logic [31:0] exp_rd;
        int          w;
        off = addr - base[inst];
        e   = (addr % 4 != 0) || (addr < base[inst]) || (off / 4 >= 256);
        w   = e ? 0 : int'(off / 4);
        exp_rd = (e || we) ? 32'h0 : mdl[inst][w];
        xact(inst, we, addr, wdata, be, hold, rdo, erro);
        check_eq("resp_err", 32'(erro), 32'(e));
        check_eq("resp_rdata", rdo, exp_rd);
        if (!e && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[inst][w][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] a;
        int          acc;
        int          inst;
        int          kind;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'h0; resp_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_req_ready", 32'(rr[i]), 32'd1);
            check_eq("rst_resp_valid", 32'(rv[i]), 32'd0);
            check_eq("rst_resp_rdata", rd[i], 32'h0);
            check_eq("rst_resp_err", 32'(rer[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 256; k++) begin
                run(i, 1'b1, base[i] + 32'(4 * k), $urandom, 4'hF, 0, r, e);
            end
        end

        run(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, r, e);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r, e);
        check_eq("store_load", r, 32'hDEADBEEF);
        run(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, r, e);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r, e);
        check_eq("byte_enable", r, 32'hDE22BE44);
        run(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, 0, r, e);
        check_eq("be_zero_err", 32'(e), 32'd0);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r, e);
        check_eq("be_zero_data", r, 32'hDE22BE44);
        run(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, r, e);
        check_eq("misaligned_err", 32'(e), 32'd1);
        run(0, 1'b1, 32'h400, 32'h12345678, 4'hF, 0, r, e);
        check_eq("range_err", 32'(e), 32'd1);
        run(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, r, e);
        run(2, 1'b0, 32'hFC, 32'h0, 4'h0, 0, r, e);
        check_eq("below_base_err", 32'(e), 32'd1);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, r, e);

        // Back-to-back loads on the zero-wait instance with resp_ready held high.
        sel = 1; req_we = 1'b0; req_addr = 32'h40; req_be = 4'hF;
        resp_ready = 1'b1; req_valid = 1'b1; acc = 0;
        for (int c = 0; c < 30; c++) begin
            if (rr[1]) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        resp_ready = 1'b0;
        check_eq("throughput", 32'(acc), 32'd10);

        // Reset while the store is waiting: it must never reach the RAM.
        sel = 0; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_req_ready", 32'(rr[0]), 32'd1);
        check_eq("midrst_resp_valid", 32'(rv[0]), 32'd0);
        check_eq("midrst_resp_rdata", rd[0], 32'h0);
        run(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, r, e);

        for (int n = 0; n < 150; n++) begin
            inst = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            case (kind)
                0: a = base[inst] + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
                1: a = (n % 2 == 0) ? 32'hFFFF_FFF0 : base[inst] + 32'h400 + 32'(4 * $urandom_range(0, 15));
                2: a = 32'(4 * $urandom_range(0, 63));
                default: a = base[inst] + 32'(4 * $urandom_range(0, 255));
            endcase
            run(inst, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), r, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
